detect_window_counter: RTL and testbench

- Sits directly downstream of the Mealy non-overlapping sequence detector and consumes its single-cycle detection output `z`.
- Counts detections over a programmable window of clock cycles, then presents the total on a valid/ready result interface.
- Flags a threshold alarm and counter saturation.
- Gives the system a rate measure of pattern hits instead of raw pulses.

---
 rtl/detect_window_counter.sv | 123 ++++++++++++
 tb/tb_detect_window_counter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/detect_window_counter.sv
// Counts single-cycle detection pulses over a programmable window of cycles and
// presents the total, a threshold alarm and a saturation flag on a valid/ready result port.
module detect_window_counter #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WIN_W  = 16,
  parameter int unsigned THRESH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             alarm,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [WIN_W-1:0] REM_ONE = WIN_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic             alarm_q, alarm_d;
  logic             start_ok;

  // A start is only meaningful with a non-zero window length.
  assign start_ok = start && (win_len != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      count_q     <= '0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      alarm_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      alarm_q     <= alarm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    count_d = count_q;
    sat_d   = sat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          rem_d   = win_len;
          count_d = '0;
          sat_d   = 1'b0;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        if (z) begin
          if (count_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        rem_d = rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_d = S_REPORT;
        end
      end

      S_REPORT: begin
        // Result backpressure: nothing moves until the consumer takes it.
        if (res_ready) begin
          if (start_ok) begin
            rem_d   = win_len;
            count_d = '0;
            sat_d   = 1'b0;
            state_d = S_COUNT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d      = (state_d == S_COUNT);
    res_valid_d = (state_d == S_REPORT);
    alarm_d     = (state_d == S_REPORT) && (32'(count_d) >= 32'(THRESH));
  end

  assign busy      = busy_q;
  assign count     = count_q;
  assign res_valid = res_valid_q;
  assign alarm     = alarm_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_detect_window_counter.sv
// Directed self-checking bench for detect_window_counter: reset, window boundaries,
// saturation, backpressure, back-to-back windows and reset mid-window.
module tb_detect_window_counter;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;

  logic             clk;
  logic             rst;
  logic             z;
  logic             start;
  logic [WIN_W-1:0] win_len;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             res_valid;
  logic             res_ready;
  logic             alarm;
  logic             sat;

  int checks;
  int failures;

  detect_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W), .THRESH(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .z        (z),
    .start    (start),
    .win_len  (win_len),
    .busy     (busy),
    .count    (count),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .alarm    (alarm),
    .sat      (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic [31:0] c,
                         input logic v, input logic a, input logic s);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'(v));
    chk({tag, ".alarm"}, 32'(alarm), 32'(a));
    chk({tag, ".sat"}, 32'(sat), 32'(s));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    start     = 1'b1;
    z         = 1'b1;
    win_len   = 16'd5;
    res_ready = 1'b0;

    // Reset dominates start and z
    step();
    chk_all("reset1", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("reset2", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    z     = 1'b0;
    step();
    chk_all("idle", 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Basic window of 10 with hits in cycles 2, 5, 9
    start   = 1'b1;
    win_len = 16'd10;
    step();
    start = 1'b0;
    chk_all("basic.accept", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      z = (k == 2 || k == 5 || k == 9);
      step();
      if (k < 10) begin
        chk("basic.busy", 32'(busy), 32'd1);
        chk("basic.nvalid", 32'(res_valid), 32'd0);
      end
      if (k == 2) chk("basic.cnt2", 32'(count), 32'd1);
      if (k == 5) chk("basic.cnt5", 32'(count), 32'd2);
    end
    chk_all("basic.report", 1'b0, 3, 1'b1, 1'b1, 1'b0);
    z = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_all("basic.hold", 1'b0, 3, 1'b1, 1'b1, 1'b0);
    end
    z         = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk_all("basic.accepted", 1'b0, 3, 1'b0, 1'b0, 1'b0);

    // Window edges: z on accept cycle and after the window is not counted
    z       = 1'b1;
    start   = 1'b1;
    win_len = 16'd4;
    step();
    start = 1'b0;
    chk("edge.accept_cnt", 32'(count), 32'd0);
    z = 1'b1; step();
    z = 1'b0; step();
    step();
    z = 1'b1; step();
    chk_all("edge.report", 1'b0, 2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("edge.after", 1'b0, 2, 1'b1, 1'b0, 1'b0);
    z         = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Saturation over a 300-cycle window with z held high
    start   = 1'b1;
    win_len = 16'd300;
    step();
    start = 1'b0;
    z     = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 255) begin
        chk("sat.cnt255", 32'(count), 32'd255);
        chk("sat.not_yet", 32'(sat), 32'd0);
      end
      if (i == 256) begin
        chk("sat.first_drop", 32'(sat), 32'd1);
        chk("sat.hold255", 32'(count), 32'd255);
      end
    end
    chk_all("sat.report", 1'b0, 255, 1'b1, 1'b1, 1'b1);
    z         = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk_all("sat.idle", 1'b0, 255, 1'b0, 1'b0, 1'b1);

    // Zero-length start is ignored in IDLE
    start   = 1'b1;
    win_len = 16'd0;
    step();
    start = 1'b0;
    chk_all("zero.ignored", 1'b0, 255, 1'b0, 1'b0, 1'b1);

    // Short window to reach REPORT with count 0
    start   = 1'b1;
    win_len = 16'd2;
    step();
    start = 1'b0;
    chk_all("b2b.open", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_all("b2b.report", 1'b0, 0, 1'b1, 1'b0, 1'b0);

    // Start without res_ready is blocked
    start   = 1'b1;
    win_len = 16'd3;
    step();
    chk_all("b2b.blocked", 1'b0, 0, 1'b1, 1'b0, 1'b0);

    // res_ready with start opens the next window directly
    res_ready = 1'b1;
    win_len   = 16'd5;
    step();
    res_ready = 1'b0;
    start     = 1'b0;
    chk_all("b2b.reopen", 1'b1, 0, 1'b0, 1'b0, 1'b0);
    z = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 5) chk("b2b.busy", 32'(busy), 32'd1);
    end
    z = 1'b0;
    chk_all("b2b.result", 1'b0, 5, 1'b1, 1'b1, 1'b0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Reset mid-window discards it
    start   = 1'b1;
    win_len = 16'd10;
    step();
    start = 1'b0;
    z     = 1'b1;
    step();
    step();
    chk("midrst.cnt2", 32'(count), 32'd2);
    z   = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("midrst.reset", 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      step();
      chk("midrst.novalid", 32'(res_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
